// File: rtl/fixed_point_multiplier_if.sv
// Operand/result bundle for the pipelined fixed-point multiplier.
// The master drives the operands and the slave (the multiplier) returns the product and its magnitude.
interface fixed_point_multiplier_if #(
    parameter int WIDTH = 13
);
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [2*WIDTH:0] Y;
    logic        [2*WIDTH:0] Z;

    modport master (output A, output B, input Y, input Z);
    modport slave  (input A, input B, output Y, output Z);
endinterface

// File: rtl/fixed_point_multiplier.sv
// Two-stage signed multiplier: radix-4 Booth partial products are registered,
// then reduced by a binary adder tree into the signed product and its magnitude.
module fixed_point_multiplier #(
    parameter int WIDTH = 13,
    parameter int FRAC  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fixed_point_multiplier_if.slave   bus
);
    localparam int OW     = 2*WIDTH + 1;
    localparam int NPP    = (WIDTH + 2) / 2;
    localparam int LEVELS = $clog2(NPP);
    localparam int NLEAF  = 1 << LEVELS;

    logic signed [OW-1:0] a_ext;
    logic        [2*NPP:0] b_ext;
    logic signed [OW-1:0] pp_next [NPP];
    logic signed [OW-1:0] pp_reg  [NPP];
    logic                 a_zero, b_zero, sign_next, sign_reg;
    logic signed [OW-1:0] sum;
    logic signed [OW-1:0] y_reg;
    logic        [OW-1:0] z_reg;

    // B gets an implicit 0 below the LSB and enough sign bits to fill the last Booth group.
    assign a_ext = {{(OW-WIDTH){bus.A[WIDTH-1]}}, bus.A};
    assign b_ext = {{(2*NPP-WIDTH){bus.B[WIDTH-1]}}, bus.B, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < NPP; gi++) begin : booth
            logic neg, one, two;
            logic signed [OW-1:0] mag;
            assign neg = b_ext[2*gi+2];
            assign one = b_ext[2*gi+1] ^ b_ext[2*gi];
            assign two = (b_ext[2*gi+2] & ~b_ext[2*gi+1] & ~b_ext[2*gi]) |
                         (~b_ext[2*gi+2] & b_ext[2*gi+1] & b_ext[2*gi]);
            assign mag = one ? a_ext : (two ? (a_ext <<< 1) : '0);
            assign pp_next[gi] = (neg ? -mag : mag) <<< (2*gi);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pp_reg[gi] <= '0;
                else        pp_reg[gi] <= pp_next[gi];
            end
        end
    endgenerate

    // Zero test is split at the binary point; the result is identical to a plain compare.
    assign a_zero    = ~|bus.A[FRAC-1:0] & ~|bus.A[WIDTH-1:FRAC];
    assign b_zero    = ~|bus.B[FRAC-1:0] & ~|bus.B[WIDTH-1:FRAC];
    assign sign_next = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & ~a_zero & ~b_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sign_reg <= 1'b0;
        else        sign_reg <= sign_next;
    end

    genvar gl;
    generate
        for (gl = 0; gl <= LEVELS; gl++) begin : lvl
            logic signed [OW-1:0] node [NLEAF >> gl];
            for (gi = 0; gi < (NLEAF >> gl); gi++) begin : n
                if (gl == 0) begin : leaf
                    if (gi < NPP) begin : used
                        assign node[gi] = pp_reg[gi];
                    end else begin : pad
                        assign node[gi] = '0;
                    end
                end else begin : add
                    assign node[gi] = lvl[gl-1].node[2*gi] + lvl[gl-1].node[2*gi+1];
                end
            end
        end
    endgenerate

    assign sum = lvl[LEVELS].node[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg <= '0;
            z_reg <= '0;
        end else begin
            y_reg <= sum;
            z_reg <= sign_reg ? -sum : sum;
        end
    end

    assign bus.Y = y_reg;
    assign bus.Z = z_reg;
endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Scoreboard bench for fixed_point_multiplier: expected results are queued as operands are
// driven and compared when they emerge two edges later.
module tb_fixed_point_multiplier;
    typedef struct {
        logic [26:0] y;
        logic [26:0] z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    fixed_point_multiplier_if #(.WIDTH(13)) bus ();

    fixed_point_multiplier #(.WIDTH(13), .FRAC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [26:0] got, input logic [26:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [12:0] a, input logic [12:0] b);
        exp_t e;
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        e.y = p[26:0];
        e.z = (p < 0) ? 27'(-p) : p[26:0];
        return e;
    endfunction

    // Drive one pair, let one edge pass, then retire the entry that has reached the outputs.
    task automatic step(input logic [12:0] a, input logic [12:0] b, input string tag);
        exp_t e;
        bus.A = a;
        bus.B = b;
        sb_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        if (sb_q.size() > 1) begin
            e = sb_q.pop_front();
            check_val({tag, ".Y"}, bus.Y, e.y);
            check_val({tag, ".Z"}, bus.Z, e.z);
        end
    endtask

    task automatic restart_queue();
        exp_t e;
        sb_q.delete();
        e.y = '0;
        e.z = '0;
        sb_q.push_back(e);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.A = 13'b0000010110000;
        bus.B = 13'b1111111101001;
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_now.Y", bus.Y, 27'd0);
        check_val("rst_now.Z", bus.Z, 27'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_hold.Y", bus.Y, 27'd0);
            check_val("rst_hold.Z", bus.Z, 27'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        restart_queue();

        for (int i = 0; i < 3; i++) step(13'b0000010110000, 13'b1111111101001, "nominal");
        check_val("nominal_lit.Y", bus.Y, 27'h7FFF030);
        check_val("nominal_lit.Z", bus.Z, 27'h0000FD0);

        for (int r = 0; r < 3; r++) begin
            step(13'b0000010110000, 13'b1111111101001, "alt_nz");
            step(13'b0000010110000, 13'b1111111101001, "alt_nz");
            step(13'd0, 13'd0, "alt_zero");
            step(13'd0, 13'd0, "alt_zero");
        end

        step(13'h1000, 13'h1000, "corner_nn");
        step(13'h1000, 13'h0FFF, "corner_np");
        check_val("corner_nn_lit.Y", bus.Y, 27'h1000000);
        check_val("corner_nn_lit.Z", bus.Z, 27'h1000000);
        step(13'h1FFF, 13'h1FFF, "corner_m1");
        check_val("corner_np_lit.Y", bus.Y, 27'h7001000);
        check_val("corner_np_lit.Z", bus.Z, 27'h0FFF000);
        step(13'h0000, 13'h0ABC, "zero_a");
        check_val("corner_m1_lit.Y", bus.Y, 27'd1);
        step(13'h1234, 13'h0000, "zero_b");

        for (int i = 0; i < 1000; i++)
            step(13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)), "random");

        // Pulse reset between edges with two nonzero results in flight.
        step(13'h0FFF, 13'h1003, "pre_rst");
        step(13'h0ABC, 13'h1DEF, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst.Y", bus.Y, 27'd0);
        check_val("mid_rst.Z", bus.Z, 27'd0);
        #3 rst_n = 1'b1;
        #1;
        restart_queue();
        for (int i = 0; i < 4; i++) step(13'h1FF0, 13'h0123, "post_rst");
        step(13'd0, 13'd0, "flush");
        step(13'd0, 13'd0, "flush");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
